// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle control unit that fetches 8-bit instructions
// from a synchronous program ROM, decodes them and drives the ULA. It owns
// the PC, the instruction register and the operand registers regA/regB, and
// moves data between the data RAM and those registers.
//
// Instruction format: [7:4] opcode, [3:0] operando (RAM address for memory ops).
//   0000-1011 ALU op (one-cycle enableULA pulse)
//   1100      STORE  RAM[operando] <= saidaULA
//   1101      LOADA  regA <= RAM[operando]
//   1110      LOADB  regB <= RAM[operando]
//   1111      HALT
//
// Optional feature: define UC_PASSO_EN to add the 'passo' input and an ESPERA
// state, so that exactly one instruction executes per passo pulse.
module unidade_controle #(
    parameter int LARGURA_PC   = 4,
    parameter int LARGURA_DADO = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
`ifdef UC_PASSO_EN
    input  logic                    passo,
`endif
    output logic [LARGURA_PC-1:0]   pc,
    input  logic [7:0]              instrucao,
    output logic [3:0]              opcode,
    output logic [3:0]              operando,
    output logic [LARGURA_DADO-1:0] regA,
    output logic [LARGURA_DADO-1:0] regB,
    output logic                    enableULA,
    input  logic [LARGURA_DADO-1:0] saidaULA,
    output logic [3:0]              endereco,
    output logic [LARGURA_DADO-1:0] dado_ram_out,
    input  logic [LARGURA_DADO-1:0] dado_ram_in,
    output logic                    we_ram,
    output logic                    parado
);

    localparam logic [3:0] OP_STORE = 4'hC;
    localparam logic [3:0] OP_LOADA = 4'hD;
    localparam logic [3:0] OP_LOADB = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

`ifdef UC_PASSO_EN
    typedef enum logic [2:0] {
        BUSCA, DECODIFICA, EXECUTA, CARREGA, PARADO, ESPERA
    } estado_t;
    // Every finished instruction parks in ESPERA until the next passo pulse.
    localparam estado_t ESTADO_INICIAL = ESPERA;
`else
    typedef enum logic [2:0] {
        BUSCA, DECODIFICA, EXECUTA, CARREGA, PARADO
    } estado_t;
    localparam estado_t ESTADO_INICIAL = BUSCA;
`endif

    estado_t                 state_q, state_d;
    logic [LARGURA_PC-1:0]   pc_q, pc_d;
    logic [7:0]              ir_q, ir_d;
    logic [LARGURA_DADO-1:0] rega_q, rega_d;
    logic [LARGURA_DADO-1:0] regb_q, regb_d;

    logic [3:0] op;
    assign op = ir_q[7:4];

    // State and datapath registers; reset is asynchronous so a reset in
    // mid-instruction aborts it without waiting for a clock edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ESTADO_INICIAL;
            pc_q    <= '0;
            ir_q    <= '0;
            rega_q  <= '0;
            regb_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples the pre-edge values of the others.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rega_q  <= rega_d;
            regb_q  <= regb_d;
        end
    end

    // Next-state and register-update logic for the fetch/decode/execute FSM.
    always_comb begin
        // NOTE: every variable gets a hold value first; a path that forgets
        // to assign one would otherwise infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rega_d  = rega_q;
        regb_d  = regb_q;
        case (state_q)
            BUSCA: begin
                state_d = DECODIFICA;
            end
            DECODIFICA: begin
                ir_d    = instrucao;
                pc_d    = pc_q + LARGURA_PC'(1);
                state_d = EXECUTA;
            end
            EXECUTA: begin
                case (op)
                    OP_LOADA, OP_LOADB: state_d = CARREGA;
                    OP_HALT:            state_d = PARADO;
                    default:            state_d = ESTADO_INICIAL;
                endcase
            end
            CARREGA: begin
                if (op == OP_LOADA) rega_d = dado_ram_in;
                else                regb_d = dado_ram_in;
                state_d = ESTADO_INICIAL;
            end
            PARADO: begin
                state_d = PARADO;
            end
`ifdef UC_PASSO_EN
            ESPERA: begin
                if (passo) state_d = BUSCA;
            end
`endif
            default: begin
                state_d = ESTADO_INICIAL;
            end
        endcase
    end

    // Outputs decoded from state and ir only; the strobes can only fire in
    // EXECUTA and the opcode ranges are disjoint, so they never overlap.
    always_comb begin
        enableULA    = 1'b0;
        we_ram       = 1'b0;
        endereco     = 4'h0;
        dado_ram_out = '0;
        parado       = 1'b0;
        case (state_q)
            EXECUTA: begin
                if (op < OP_STORE) begin
                    enableULA = 1'b1;
                end else if (op == OP_STORE) begin
                    we_ram       = 1'b1;
                    endereco     = ir_q[3:0];
                    dado_ram_out = saidaULA;
                end else if (op != OP_HALT) begin
                    endereco = ir_q[3:0];
                end
            end
            CARREGA: begin
                endereco = ir_q[3:0];
            end
            PARADO: begin
                parado = 1'b1;
            end
            default: begin
                parado = 1'b0;
            end
        endcase
    end

    assign pc       = pc_q;
    assign opcode   = ir_q[7:4];
    assign operando = ir_q[3:0];
    assign regA     = rega_q;
    assign regB     = regb_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed testbench for unidade_controle with small behavioural models of
// the synchronous program ROM, data RAM and a registered ULA around it.
module tb_unidade_controle;

    logic       clock;
    logic       resetn;
    logic [3:0] pc;
    logic [7:0] instrucao;
    logic [3:0] opcode;
    logic [3:0] operando;
    logic [7:0] regA;
    logic [7:0] regB;
    logic       enableULA;
    logic [7:0] saidaULA;
    logic [3:0] endereco;
    logic [7:0] dado_ram_out;
    logic [7:0] dado_ram_in;
    logic       we_ram;
    logic       parado;
`ifdef UC_PASSO_EN
    logic       passo;
`endif

    logic [7:0] rom [16];
    logic [7:0] ram [16];

    int n_checks = 0;
    int n_errors = 0;

    // Activity monitor, written only here.
    int         n_en = 0;
    int         n_we = 0;
    int         n_both = 0;
    logic [3:0] last_en_op = '0;
    logic [3:0] last_we_addr = '0;
    logic [7:0] last_we_data = '0;

    unidade_controle #(.LARGURA_PC(4), .LARGURA_DADO(8)) dut (
        .clock        (clock),
        .resetn       (resetn),
`ifdef UC_PASSO_EN
        .passo        (passo),
`endif
        .pc           (pc),
        .instrucao    (instrucao),
        .opcode       (opcode),
        .operando     (operando),
        .regA         (regA),
        .regB         (regB),
        .enableULA    (enableULA),
        .saidaULA     (saidaULA),
        .endereco     (endereco),
        .dado_ram_out (dado_ram_out),
        .dado_ram_in  (dado_ram_in),
        .we_ram       (we_ram),
        .parado       (parado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM: data valid one cycle after pc.
    always @(posedge clock) instrucao <= rom[pc];

    // Synchronous RAM: read data valid one cycle after endereco.
    always @(posedge clock) begin
        if (we_ram) ram[endereco] <= dado_ram_out;
        dado_ram_in <= ram[endereco];
    end

    // Registered ULA: 0001 adds, anything else passes regA through.
    always @(posedge clock or negedge resetn) begin
        if (!resetn)        saidaULA <= 8'h00;
        else if (enableULA) saidaULA <= (opcode == 4'h1) ? regA + regB : regA;
    end

    always @(negedge clock) begin
        if (resetn) begin
            if (enableULA) begin
                n_en       <= n_en + 1;
                last_en_op <= opcode;
            end
            if (we_ram) begin
                n_we         <= n_we + 1;
                last_we_addr <= endereco;
                last_we_data <= dado_ram_out;
            end
            if (enableULA && we_ram) n_both <= n_both + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem(input logic [7:0] rom_fill);
        for (int i = 0; i < 16; i++) begin
            rom[i] = rom_fill;
            ram[i] = 8'h00;
        end
    endtask

    // Holds reset for 3 cycles; reset is released by release_reset().
    task automatic hold_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    int en0, we0, prev, pulses, bad_gap;

    initial begin
        resetn = 1'b0;
`ifdef UC_PASSO_EN
        passo = 1'b0;
`endif
        fill_mem(8'hF0);
        rom[0] = 8'hD3;

        // 1. Reset values
        hold_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_regA", 32'(regA), 0);
        check("rst_regB", 32'(regB), 0);
        check("rst_en", 32'(enableULA), 0);
        check("rst_we", 32'(we_ram), 0);
        check("rst_parado", 32'(parado), 0);
        check("rst_endereco", 32'(endereco), 0);
        check("rst_dado_out", 32'(dado_ram_out), 0);

`ifdef UC_PASSO_EN
        // Step mode: nothing runs without passo, one pulse = one instruction.
        fill_mem(8'h10);
        en0 = n_en;
        release_reset();
        edges(10);
        check("passo_idle_pc", 32'(pc), 0);
        check("passo_idle_en", 32'(n_en - en0), 0);
        @(negedge clock); passo = 1'b1;
        @(negedge clock); passo = 1'b0;
        edges(10);
        check("passo_one_en", 32'(n_en - en0), 1);
        check("passo_one_pc", 32'(pc), 1);
`else
        // 1b/2. Load A: ROM[0]=D3, RAM[3]=05
        ram[3] = 8'h05;
        we0 = n_we;
        release_reset();
        edges(1);
        check("busca_pc", 32'(pc), 0);
        edges(1);
        check("decod_pc", 32'(pc), 1);
        edges(1);
        check("loada_regA_early", 32'(regA), 0);
        check("loada_endereco", 32'(endereco), 3);
        edges(1);
        check("loada_regA", 32'(regA), 8'h05);
        check("loada_pc", 32'(pc), 1);
        check("loada_no_we", 32'(n_we - we0), 0);

        // 3. D3, E4, 10, C5 -> RAM[5] = 5 + 7
        hold_reset();
        fill_mem(8'hF0);
        rom[0] = 8'hD3; rom[1] = 8'hE4; rom[2] = 8'h10; rom[3] = 8'hC5;
        ram[3] = 8'h05; ram[4] = 8'h07;
        en0 = n_en; we0 = n_we;
        release_reset();
        edges(14);
        check("add_regA", 32'(regA), 8'h05);
        check("add_regB", 32'(regB), 8'h07);
        check("add_en_pulses", 32'(n_en - en0), 1);
        check("add_en_opcode", 32'(last_en_op), 1);
        check("store_we_cycles", 32'(n_we - we0), 1);
        check("store_addr", 32'(last_we_addr), 5);
        check("store_data", 32'(last_we_data), 8'h0C);
        check("store_ram5", 32'(ram[5]), 8'h0C);

        // 4. Halt: 10, F0
        hold_reset();
        fill_mem(8'h00);
        rom[0] = 8'h10; rom[1] = 8'hF0;
        release_reset();
        edges(5);
        check("halt_not_yet", 32'(parado), 0);
        edges(1);
        check("halt_parado", 32'(parado), 1);
        en0 = n_en; we0 = n_we;
        edges(20);
        check("halt_stay", 32'(parado), 1);
        check("halt_pc", 32'(pc), 2);
        check("halt_no_en", 32'(n_en - en0), 0);
        check("halt_no_we", 32'(n_we - we0), 0);

        // 5. PC wrap with an all-zero ROM
        hold_reset();
        fill_mem(8'h00);
        release_reset();
        prev = -1; pulses = 0; bad_gap = 0;
        for (int c = 1; c <= 48; c++) begin
            edges(1);
            if (enableULA) begin
                if (prev >= 0 && c - prev != 3) bad_gap++;
                prev = c;
                pulses++;
            end
            if (c == 44) check("wrap_pc15", 32'(pc), 15);
            if (c == 47) check("wrap_pc0", 32'(pc), 0);
        end
        check("wrap_pulses", 32'(pulses), 16);
        check("wrap_spacing", 32'(bad_gap), 0);

        // 6. Asynchronous reset during CARREGA of D3 with RAM[3]=AA
        hold_reset();
        fill_mem(8'hF0);
        rom[0] = 8'hD3;
        ram[3] = 8'hAA;
        we0 = n_we;
        release_reset();
        edges(3);
        check("carrega_pc", 32'(pc), 1);
        check("carrega_endereco", 32'(endereco), 3);
        #1 resetn = 1'b0;
        #1;
        check("async_regA", 32'(regA), 0);
        check("async_pc", 32'(pc), 0);
        check("async_endereco", 32'(endereco), 0);
        edges(1);
        check("async_regA_held", 32'(regA), 0);
        check("async_no_we", 32'(n_we - we0), 0);
`endif

        check("en_we_overlap", 32'(n_both), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Multi-cycle control unit that fetches 8-bit instructions from program memory, decodes them and drives the ULA.
- Owns the PC, instruction register and operand registers regA/regB; outputs regA/regB/opcode/enableULA to the ULA.
- Moves data between data RAM and the registers, and writes the ULA result back to RAM.
- Instruction format: [7:4] opcode, [3:0] operando (RAM address for memory ops).

Parameters:
LARGURA_PC, 4, program counter width; program memory depth 2^LARGURA_PC.
LARGURA_DADO, 8, width of regA, regB, saidaULA and RAM data.

Ports:
clock  input  1  system clock, rising edge.
resetn  input  1  asynchronous active-low reset.
pc  output  LARGURA_PC  program memory address.
instrucao  input  8  program memory data; synchronous ROM, valid 1 cycle after pc.
opcode  output  4  ir[7:4], to ULA.
operando  output  4  ir[3:0], to ULA.
regA  output  LARGURA_DADO  operand A register, to ULA.
regB  output  LARGURA_DADO  operand B register, to ULA.
enableULA  output  1  ULA enable, one-cycle pulse.
saidaULA  input  LARGURA_DADO  registered ULA result.
endereco  output  4  data RAM address.
dado_ram_out  output  LARGURA_DADO  RAM write data.
dado_ram_in  input  LARGURA_DADO  RAM read data; synchronous, valid 1 cycle after endereco.
we_ram  output  1  RAM write enable.
parado  output  1  high while halted.

Behaviour:
- Reset (resetn=0, async, no clock needed): state=BUSCA, pc=0, ir=0, regA=0, regB=0. Outputs: enableULA=0, we_ram=0, parado=0, endereco=0, dado_ram_out=0.
- Outputs are decoded combinationally from state and ir; all registers update on the clock rising edge.
- BUSCA: pc drives ROM. Next state: DECODIFICA.
- DECODIFICA: ir <= instrucao; pc <= pc+1, wrapping 2^LARGURA_PC-1 -> 0. Next state: EXECUTA.
- EXECUTA, by opcode:
  - 0000-1011 (ALU ops): enableULA=1 for this cycle only. Next state: BUSCA. The ULA registers saidaULA at the end of this cycle. The result is not written back to regA/regB.
  - 1100 STORE: we_ram=1, endereco=operando, dado_ram_out=saidaULA for exactly this cycle. Next state: BUSCA.
  - 1101 LOADA / 1110 LOADB: endereco=operando, we_ram=0. Next state: CARREGA.
  - 1111 HALT: next state: PARADO.
- CARREGA: endereco=operando held. regA (1101) or regB (1110) <= dado_ram_in. Next state: BUSCA.
- PARADO: parado=1. pc and all registers frozen; enableULA=0, we_ram=0. Only reset exits this state.
- Latency in cycles: ALU op 3, STORE 3, LOAD 4, HALT 3 then stop.
- enableULA and we_ram are never high in the same cycle, and never high outside EXECUTA.
- A STORE immediately after an ALU op writes that op's result: saidaULA is valid from BUSCA onward.
- Reset mid-instruction aborts it with no partial RAM write. A load interrupted in CARREGA leaves its target register at 0.
- Division by zero and ALU arithmetic are the ULA's concern; the controller is opcode-agnostic for 0000-1011.

Optional Feature:
Macro UC_PASSO_EN.
- Defined: adds input port passo (1 bit) and a state ESPERA, entered from BUSCA's predecessor. The FSM leaves ESPERA for BUSCA only in a cycle where passo=1, so exactly one instruction executes per passo pulse. Reset enters ESPERA instead of BUSCA; the reset values of all outputs are unchanged.
- Undefined: no passo port and no ESPERA state; the FSM free-runs as described above.

Test Plan:
1. Reset check: resetn=0 for 3 cycles -> pc=0, regA=regB=0, enableULA=0, we_ram=0, parado=0. After release, pc=0 for the first BUSCA and pc=1 after DECODIFICA.
2. Load: ROM[0]=0xD3, RAM[3]=0x05 -> regA=0x05 four cycles after reset release, pc=1, we_ram never asserted.
3. Add and store: program D3, E4, 10, C5 with RAM[3]=0x05, RAM[4]=0x07 -> enableULA high for exactly one cycle with opcode=0001; RAM[5]=0x0C written in a single we_ram cycle with endereco=5.
4. Halt: program 10, F0 -> parado=1 from cycle 6 onward; pc stays 2 and enableULA/we_ram stay 0 for 20 further cycles.
5. PC wrap: LARGURA_PC=4, ROM filled with 0x00 -> after 16 instructions pc goes 15 -> 0; 16 enableULA pulses spaced 3 cycles apart.
6. Async reset: assert resetn=0 mid-CARREGA of 0xD3 (RAM[3]=0xAA) -> regA=0 and pc=0 immediately, without a clock edge. With UC_PASSO_EN defined, a single passo pulse executes exactly one instruction.
